inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage. Generates the word address and read enable for the instruction memory, captures the returned word, and presents {instruction, PC, valid} to decode. Handles decode back-pressure (stall), branch/jump redirects and EBREAK halt. Sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
Parameters:
- AW, 5, instruction-memory word-address width (memory depth 2^AW words)
- DW, 32, instruction width
- RESET_PC, 0, word address fetched first after reset

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- stall_i  in  1  decode cannot accept; hold current outputs
- redirect_i  in  1  taken branch/jump; restart fetch at redirect_pc_i
- redirect_pc_i  in  AW  redirect target, word address
- mem_addr_o  out  AW  instruction-memory word address (= fetch_pc register)
- mem_rd_en_o  out  1  instruction-memory read enable (registered, = state RUN)
- mem_data_i  in  DW  instruction-memory read data, valid at the rising edge ending a cycle in which mem_rd_en_o=1
- inst_o  out  DW  instruction to decode
- pc_o  out  AW  word address of inst_o
- inst_valid_o  out  1  inst_o/pc_o hold a real instruction
- halted_o  out  1  EBREAK fetched; fetch stopped

## Operation
- Memory contract: address/enable driven during cycle N are read by memory mid-cycle; data is sampled by this block at the rising edge closing cycle N. Address-to-inst_o latency: 1 cycle.
- States: IDLE, RUN, STALL, HALT. mem_rd_en_o=1 only in RUN.
- Priority at each edge: reset > redirect_i > stall_i > normal.
- IDLE (one cycle after reset, lets memory finish its reset load): next state RUN; inst_valid_o<=0. Redirect in IDLE: fetch_pc<=redirect_pc_i, go RUN.
- RUN, no redirect, no stall: inst_o<=mem_data_i, pc_o<=fetch_pc, inst_valid_o<=1, fetch_pc<=fetch_pc+1 (mod 2^AW, 2^AW-1 wraps to 0).
- RUN, mem_data_i==32'h0010_0073 (EBREAK), no redirect/stall: capture as above with inst_valid_o<=1, fetch_pc not incremented, halted_o<=1, go HALT.
- RUN or STALL, stall_i=1 (no redirect): inst_o, pc_o, inst_valid_o, fetch_pc hold; read data discarded; go/stay STALL.
- STALL, stall_i=0: decode accepts held instruction at this edge; inst_valid_o<=0; go RUN (one bubble).
- Redirect (RUN/STALL/IDLE): fetch_pc<=redirect_pc_i, inst_valid_o<=0, in-flight data discarded, go RUN. Redirect wins over simultaneous stall_i.
- HALT: mem_rd_en_o=0; inst_valid_o<=0 at first HALT edge; inst_o/pc_o hold; redirect_i and stall_i ignored; exit only by reset.

## Timing
- Reset values (asynchronous): state IDLE, fetch_pc=mem_addr_o=RESET_PC, mem_rd_en_o=0, inst_o=0, pc_o=0, inst_valid_o=0, halted_o=0.
- After rst_i falls: edge 1 IDLE->RUN; cycle 2 first read of RESET_PC; edge 2 first inst_valid_o=1.
- Steady state: one instruction per cycle, pc_o increments by 1 each edge.
- Redirect penalty: one inst_valid_o=0 cycle; target appears on pc_o at the second edge after redirect_i sampled.
- Stall release penalty: one inst_valid_o=0 cycle.
- Reset mid-operation: all outputs return to reset values immediately, independent of clock.
- No combinational path from any input to any output.

## Test plan
- Reset release, memory word0=32'h0000_2083, word1=32'h0010_2103: edge 2 inst_o=32'h0000_2083 pc_o=0 valid=1; edge 3 pc_o=1 inst_o=32'h0010_2103; mem_rd_en_o=0 through edge 1.
- stall_i high 3 edges while pc_o=2 valid: pc_o=2, valid=1 held, mem_rd_en_o=0 in STALL; release edge valid=0; next edge pc_o=3.
- redirect_i with redirect_pc_i=7 at edge where pc_o becomes 4: next edge valid=0; following edge pc_o=7, inst_o=mem[7].
- redirect_i and stall_i high same edge, target 5: redirect taken, valid=0, then pc_o=5 despite stall history.
- Redirect to 31, run: pc_o=31 then pc_o=0 (wrap); mem[9]=32'h0010_0073 later: pc_o=9 valid=1, halted_o=1, next edge valid=0, mem_rd_en_o stays 0, redirect_i ignored.
- Assert rst_i mid-cycle while in RUN: inst_valid_o, mem_rd_en_o, halted_o drop to 0 and mem_addr_o=RESET_PC before next clock edge; normal restart after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Drives the instruction-memory word address and read enable, captures the
// returned word one cycle later and presents {inst, pc, valid} to decode.
// Decode back-pressure holds the presented instruction, a redirect restarts
// fetch at a new target, and an EBREAK word parks the stage until reset.
// Every output is a register (or a decode of the state register), so no
// input reaches an output combinationally.
//
// Handshake: inst_o/pc_o are offered while inst_valid_o=1. Decode signals
// "not taken" by raising stall_i; an instruction is consumed at every rising
// edge where inst_valid_o=1 and stall_i=0. redirect_i overrides stall_i.
//
// dbg_state_o encoding: 0=IDLE, 1=RUN, 2=STALL, 3=HALT.
module inst_fetch #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int RESET_PC = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_en_o,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] pc_o,
  output logic          inst_valid_o,
  output logic          halted_o,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [DW-1:0] EBREAK = DW'(32'h0010_0073);

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q;
  logic [DW-1:0] inst_q;
  logic [AW-1:0] pc_q;
  logic          valid_q;
  logic          halted_q;

  // Control strobes from the next-state logic into the datapath.
  logic          capture;       // take mem_data_i into the decode registers
  logic          load_redirect; // restart fetch at redirect_pc_i
  logic          clear_valid;   // present a bubble to decode
  logic          set_halt;      // EBREAK captured, stop fetching
  logic          is_ebreak;

  assign is_ebreak = (mem_data_i == EBREAK);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath strobes; priority is redirect > stall > normal.
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    load_redirect = 1'b0;
    clear_valid   = 1'b0;
    set_halt      = 1'b0;
    case (state_q)
      IDLE: begin
        // One settling cycle for the memory before the first read.
        state_d       = RUN;
        clear_valid   = 1'b1;
        load_redirect = redirect_i;
      end
      RUN: begin
        if (redirect_i) begin
          load_redirect = 1'b1;
          clear_valid   = 1'b1;
        end else if (stall_i) begin
          // Read data this cycle is dropped; the same address is re-read later.
          state_d = STALL;
        end else begin
          capture = 1'b1;
          if (is_ebreak) begin
            set_halt = 1'b1;
            state_d  = HALT;
          end
        end
      end
      STALL: begin
        if (redirect_i) begin
          load_redirect = 1'b1;
          clear_valid   = 1'b1;
          state_d       = RUN;
        end else if (!stall_i) begin
          // Decode takes the held instruction now; one bubble follows.
          clear_valid = 1'b1;
          state_d     = RUN;
        end
      end
      HALT: begin
        clear_valid = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch PC and decode-facing registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= AW'(RESET_PC);
      inst_q     <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (load_redirect)              fetch_pc_q <= redirect_pc_i;
      else if (capture && !is_ebreak) fetch_pc_q <= fetch_pc_q + AW'(1);
      if (capture) begin
        inst_q  <= mem_data_i;
        pc_q    <= fetch_pc_q;
        valid_q <= 1'b1;
      end else if (clear_valid) begin
        valid_q <= 1'b0;
      end
      if (set_halt) halted_q <= 1'b1;
    end
  end

  assign mem_addr_o   = fetch_pc_q;
  assign mem_rd_en_o  = (state_q == RUN);
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = valid_q;
  assign halted_o     = halted_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: behavioural instruction memory, per-scenario
// tasks with inline checks, and a scoreboard of expected {pc, inst} pairs
// popped whenever decode consumes a fresh instruction.
module tb_inst_fetch;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [DW-1:0] EBREAK = 32'h0010_0073;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_HALT = 2'd3;

  logic          clk_i;
  logic          rst_i;
  logic          stall_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_en_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] pc_o;
  logic          inst_valid_o;
  logic          halted_o;
  logic [1:0]    dbg_state_o;

  logic [DW-1:0] mem [32];
  logic [AW+DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  inst_fetch #(.AW(AW), .DW(DW), .RESET_PC(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_data_i(mem_data_i), .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o),
    .halted_o(halted_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and asynchronous-read memory model.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  assign mem_data_i = mem[mem_addr_o];

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: a new instruction is consumed when valid=1 after an edge
  // that sampled stall_i=0.
  logic             mon_stall;
  logic [AW+DW-1:0] mon_exp;
  always @(posedge clk_i) begin
    mon_stall = stall_i;
    #1;
    if (!rst_i && inst_valid_o && !mon_stall) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got pc=%0d inst=%h want none", pc_o, inst_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({pc_o, inst_o} !== mon_exp) begin
          bad++;
          $display("FAIL sb_order: got pc=%0d inst=%h want pc=%0d inst=%h",
                   pc_o, inst_o, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int a);
    exp_q.push_back({AW'(a), mem[a]});
  endtask

  task automatic test_reset();
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #1 rst_i = 1'b1;
    #2;
    total++;
    if ({mem_addr_o, mem_rd_en_o, inst_o, pc_o, inst_valid_o, halted_o, dbg_state_o} !==
        {5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, S_IDLE}) begin
      bad++;
      $display("FAIL reset_values: got addr=%0d rd=%b inst=%h pc=%0d v=%b h=%b st=%0d want all zero",
               mem_addr_o, mem_rd_en_o, inst_o, pc_o, inst_valid_o, halted_o, dbg_state_o);
    end
    tick(); tick();
    total++;
    if ({mem_rd_en_o, inst_valid_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: got rd=%b v=%b want 0 0", mem_rd_en_o, inst_valid_o);
    end
  endtask

  task automatic test_start();
    rst_i = 1'b0;
    push(0); push(1); push(2);
    total++;
    if (mem_rd_en_o !== 1'b0) begin
      bad++; $display("FAIL start_rd_pre: got %b want 0", mem_rd_en_o);
    end
    tick(); // edge 1
    total++;
    if ({inst_valid_o, mem_rd_en_o, dbg_state_o, mem_addr_o} !== {1'b0, 1'b1, S_RUN, 5'd0}) begin
      bad++;
      $display("FAIL start_edge1: got v=%b rd=%b st=%0d addr=%0d want 0 1 1 0",
               inst_valid_o, mem_rd_en_o, dbg_state_o, mem_addr_o);
    end
    tick(); // edge 2
    total++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 5'd0, 32'h0000_2083}) begin
      bad++;
      $display("FAIL start_edge2: got v=%b pc=%0d inst=%h want 1 0 00002083", inst_valid_o, pc_o, inst_o);
    end
    tick(); // edge 3
    total++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 5'd1, 32'h0010_2103}) begin
      bad++;
      $display("FAIL start_edge3: got v=%b pc=%0d inst=%h want 1 1 00102103", inst_valid_o, pc_o, inst_o);
    end
    tick(); // pc_o = 2
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    push(3); push(4);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, pc_o, inst_o} !==
          {1'b1, 1'b0, 1'b0, S_STALL, 5'd2, mem[2]}) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b rd=%b st=%0d pc=%0d inst=%h want 1 0 2 2 %h",
                 i, inst_valid_o, mem_rd_en_o, dbg_state_o, pc_o, inst_o, mem[2]);
      end
    end
    stall_i = 1'b0;
    tick();
    total++;
    if ({inst_valid_o, mem_rd_en_o, dbg_state_o, mem_addr_o} !== {1'b0, 1'b1, S_RUN, 5'd3}) begin
      bad++;
      $display("FAIL stall_release: got v=%b rd=%b st=%0d addr=%0d want 0 1 1 3",
               inst_valid_o, mem_rd_en_o, dbg_state_o, mem_addr_o);
    end
    tick();
    total++;
    if ({inst_valid_o, pc_o} !== {1'b1, 5'd3}) begin
      bad++; $display("FAIL stall_resume: got v=%b pc=%0d want 1 3", inst_valid_o, pc_o);
    end
    tick(); // pc_o = 4
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 5'd7;
    push(7); push(8);
    tick();
    total++;
    if ({inst_valid_o, mem_addr_o, dbg_state_o} !== {1'b0, 5'd7, S_RUN}) begin
      bad++;
      $display("FAIL redir_bubble: got v=%b addr=%0d st=%0d want 0 7 1", inst_valid_o, mem_addr_o, dbg_state_o);
    end
    redirect_i = 1'b0;
    tick();
    total++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 5'd7, mem[7]}) begin
      bad++;
      $display("FAIL redir_target: got v=%b pc=%0d inst=%h want 1 7 %h", inst_valid_o, pc_o, inst_o, mem[7]);
    end
    tick(); // pc_o = 8
  endtask

  task automatic test_redirect_stall();
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 5'd5;
    push(5); push(6);
    tick();
    total++;
    if ({inst_valid_o, mem_addr_o, dbg_state_o} !== {1'b0, 5'd5, S_RUN}) begin
      bad++;
      $display("FAIL redir_stall: got v=%b addr=%0d st=%0d want 0 5 1", inst_valid_o, mem_addr_o, dbg_state_o);
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    tick();
    total++;
    if ({inst_valid_o, pc_o} !== {1'b1, 5'd5}) begin
      bad++; $display("FAIL redir_stall_target: got v=%b pc=%0d want 1 5", inst_valid_o, pc_o);
    end
    tick(); // pc_o = 6
  endtask

  task automatic test_wrap_halt();
    mem[9] = EBREAK;
    redirect_i = 1'b1; redirect_pc_i = 5'd31;
    push(31);
    for (int a = 0; a <= 9; a++) push(a);
    tick();
    redirect_i = 1'b0;
    tick();
    total++;
    if ({inst_valid_o, pc_o} !== {1'b1, 5'd31}) begin
      bad++; $display("FAIL wrap_31: got v=%b pc=%0d want 1 31", inst_valid_o, pc_o);
    end
    tick();
    total++;
    if ({inst_valid_o, pc_o, mem_addr_o} !== {1'b1, 5'd0, 5'd1}) begin
      bad++; $display("FAIL wrap_0: got v=%b pc=%0d addr=%0d want 1 0 1", inst_valid_o, pc_o, mem_addr_o);
    end
    repeat (8) tick(); // pc_o 1..8
    tick();
    total++;
    if ({inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, pc_o, inst_o, mem_addr_o} !==
        {1'b1, 1'b0, 1'b1, S_HALT, 5'd9, EBREAK, 5'd9}) begin
      bad++;
      $display("FAIL halt_entry: got v=%b rd=%b h=%b st=%0d pc=%0d inst=%h addr=%0d want 1 0 1 3 9 00100073 9",
               inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, pc_o, inst_o, mem_addr_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 5'd3; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, pc_o, inst_o, mem_addr_o} !==
          {1'b0, 1'b0, 1'b1, S_HALT, 5'd9, EBREAK, 5'd9}) begin
        bad++;
        $display("FAIL halt_hold%0d: got v=%b rd=%b h=%b st=%0d pc=%0d inst=%h addr=%0d want 0 0 1 3 9 00100073 9",
                 i, inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, pc_o, inst_o, mem_addr_o);
      end
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL halt_sb_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    rst_i = 1'b1;
    #1;
    total++;
    if ({inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, mem_addr_o} !== {1'b0, 1'b0, 1'b0, S_IDLE, 5'd0}) begin
      bad++;
      $display("FAIL halt_reset: got v=%b rd=%b h=%b st=%0d addr=%0d want 0 0 0 0 0",
               inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, mem_addr_o);
    end
    tick();
    rst_i = 1'b0;
    push(0); push(1); push(2);
    repeat (4) tick(); // edge1, pc0, pc1, pc2 -- running in RUN
    #3 rst_i = 1'b1;
    #1;
    total++;
    if ({inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, mem_addr_o} !== {1'b0, 1'b0, 1'b0, S_IDLE, 5'd0}) begin
      bad++;
      $display("FAIL async_reset: got v=%b rd=%b h=%b st=%0d addr=%0d want 0 0 0 0 0",
               inst_valid_o, mem_rd_en_o, halted_o, dbg_state_o, mem_addr_o);
    end
    tick();
    rst_i = 1'b0;
    push(0); push(1);
    tick();
    total++;
    if ({inst_valid_o, mem_rd_en_o} !== 2'b01) begin
      bad++; $display("FAIL restart_edge1: got v=%b rd=%b want 0 1", inst_valid_o, mem_rd_en_o);
    end
    tick();
    tick();
    total++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 5'd1, mem[1]}) begin
      bad++;
      $display("FAIL restart_run: got v=%b pc=%0d inst=%h want 1 1 %h", inst_valid_o, pc_o, inst_o, mem[1]);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_sb_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom_range(32'hFFFF_FFFF, 0);
      if (mem[i] == EBREAK) mem[i] = ~EBREAK;
    end
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0010_2103;
    test_reset();
    test_start();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
